// File: rtl/tinyqv_div_sequencer_pkg.sv
// Shared definitions for the TinyQV division sequencer: ALU opcodes it issues,
// op-field bit positions and the sequencer state enumeration.
package tinyqv_div_sequencer_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  localparam int unsigned OP_UNSIGNED = 0;
  localparam int unsigned OP_REM      = 1;

  typedef enum logic [2:0] {
    StIdle,
    StAbsA,
    StAbsB,
    StCmp,
    StSub,
    StFixQ,
    StFixR,
    StDone
  } div_state_e;

endpackage

// File: rtl/tinyqv_div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer. Borrows the shared ALU through a
// request/grant port and runs a 32-step restoring division on its SUB and SLTU.
module tinyqv_div_sequencer
  import tinyqv_div_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_d,
  input  logic        alu_cmp
);

  div_state_e  state_q, state_d;
  logic [31:0] q_q, q_d;        // dividend, shifted into quotient
  logic [31:0] r_q, r_d;        // partial remainder
  logic [31:0] d_q, d_d;        // divisor magnitude
  logic [4:0]  cnt_q, cnt_d;
  logic        take_q, take_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        is_rem_q, is_rem_d;
  logic        is_signed_q, is_signed_d;
  logic [31:0] result_q, result_d;

  logic [31:0] rs;
  logic        hi;

  assign rs     = {r_q[30:0], q_q[31]};
  assign hi     = r_q[31];
  assign result = result_q;

  // Next-state, datapath updates and ALU port drive
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    take_d      = take_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    is_rem_d    = is_rem_q;
    is_signed_d = is_signed_q;
    result_d    = result_q;
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    alu_req     = 1'b0;
    alu_op      = '0;
    alu_a       = '0;
    alu_b       = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          q_d         = a;
          d_d         = b;
          r_d         = '0;
          cnt_d       = '0;
          take_d      = 1'b0;
          is_rem_d    = op[OP_REM];
          is_signed_d = ~op[OP_UNSIGNED];
          neg_quo_d   = ~op[OP_UNSIGNED] & (a[31] ^ b[31]);
          neg_rem_d   = ~op[OP_UNSIGNED] & a[31];
          if (b == '0) begin
            // Divide by zero never touches the ALU
            result_d = op[OP_REM] ? a : 32'hFFFF_FFFF;
            state_d  = StDone;
          end else begin
            state_d = StAbsA;
          end
        end
      end
      StAbsA: begin
        alu_req = 1'b1;
        alu_op  = ALU_SUB;
        alu_b   = q_q;
        if (alu_gnt) begin
          if (is_signed_q && q_q[31]) q_d = alu_d;
          state_d = StAbsB;
        end
      end
      StAbsB: begin
        alu_req = 1'b1;
        alu_op  = ALU_SUB;
        alu_b   = d_q;
        if (alu_gnt) begin
          if (is_signed_q && d_q[31]) d_d = alu_d;
          state_d = StCmp;
        end
      end
      StCmp: begin
        alu_req = 1'b1;
        alu_op  = ALU_SLTU;
        alu_a   = rs;
        alu_b   = d_q;
        if (alu_gnt) begin
          // The shifted-out bit makes Rs >= 2^32 > D, so hi forces a take
          take_d  = hi | ~alu_cmp;
          state_d = StSub;
        end
      end
      StSub: begin
        alu_req = 1'b1;
        alu_op  = ALU_SUB;
        alu_a   = rs;
        alu_b   = d_q;
        if (alu_gnt) begin
          r_d     = take_q ? alu_d : rs;
          q_d     = {q_q[30:0], take_q};
          cnt_d   = cnt_q + 5'd1;
          state_d = (cnt_q == 5'd31) ? StFixQ : StCmp;
        end
      end
      StFixQ: begin
        alu_req = 1'b1;
        alu_op  = ALU_SUB;
        alu_b   = q_q;
        if (alu_gnt) begin
          if (neg_quo_q) q_d = alu_d;
          state_d = StFixR;
        end
      end
      StFixR: begin
        alu_req = 1'b1;
        alu_op  = ALU_SUB;
        alu_b   = r_q;
        if (alu_gnt) begin
          if (neg_rem_q) r_d = alu_d;
          result_d = is_rem_q ? (neg_rem_q ? alu_d : r_q) : q_q;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      take_q      <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      is_rem_q    <= 1'b0;
      is_signed_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      take_q      <= take_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      is_rem_q    <= is_rem_d;
      is_signed_q <= is_signed_d;
      result_q    <= result_d;
    end
  end

endmodule

// File: tb/tb_tinyqv_div_sequencer.sv
// Scoreboard bench for tinyqv_div_sequencer: a driver issues divisions and queues
// the expected result, done cycle and ALU-request count; a monitor checks them.
module tb_tinyqv_div_sequencer;
  import tinyqv_div_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic        alu_req, alu_gnt;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_d;
  logic        alu_cmp;

  tinyqv_div_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .alu_req (alu_req),
    .alu_gnt (alu_gnt),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_d   (alu_d),
    .alu_cmp (alu_cmp)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU
  always_comb begin
    alu_cmp = (alu_op == ALU_SLTU) && (alu_a < alu_b);
    case (alu_op)
      ALU_ADD:  alu_d = alu_a + alu_b;
      ALU_SUB:  alu_d = alu_a - alu_b;
      ALU_SLTU: alu_d = {31'b0, alu_a < alu_b};
      default:  alu_d = '0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    int          nreq;
    string       name;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           acc_cyc = -1000;
  logic [127:0] stall_mask = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Behavioural RISC-V M-extension division semantics
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    int sx, sy;
    if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
    if (o[0]) return o[1] ? x % y : x / y;
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    sx = x;
    sy = y;
    return o[1] ? 32'(sx % sy) : 32'(sx / sy);
  endfunction

  // Grant driver: drops alu_gnt on the chosen cycle offsets after accept
  initial begin
    int n;
    alu_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      n = cyc - acc_cyc + 1;
      alu_gnt = !(n >= 1 && n < 128 && stall_mask[n]);
    end
  end

  // Monitor: pops the scoreboard on done and checks stall stability
  initial begin
    exp_t        e;
    int          req_cnt;
    logic        prev_req, prev_gnt;
    logic [3:0]  prev_op;
    logic [31:0] prev_a, prev_b;
    req_cnt  = 0;
    prev_req = 1'b0;
    prev_gnt = 1'b1;
    prev_op  = '0;
    prev_a   = '0;
    prev_b   = '0;
    forever begin
      @(negedge clk);
      if (prev_req && !prev_gnt) begin
        check("stall_alu_op", {28'b0, alu_op}, {28'b0, prev_op});
        check("stall_alu_a", alu_a, prev_a);
        check("stall_alu_b", alu_b, prev_b);
      end
      if (busy && alu_req) req_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.due));
          check({e.name, "_alu_req_cycles"}, 32'(req_cnt), 32'(e.nreq));
        end
        req_cnt = 0;
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        check({e.name, "_timeout"}, 32'(cyc), 32'(e.due));
      end
      if (!busy) req_cnt = 0;
      prev_req = alu_req;
      prev_gnt = alu_gnt;
      prev_op  = alu_op;
      prev_a   = alu_a;
      prev_b   = alu_b;
    end
  end

  // Waits for idle, plants the stall cycles, pulses start and queues the expectation
  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int stalls, input logic [31:0] exp);
    int   guard;
    int   cnt;
    int   n;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_idle_wait"}, {31'b0, busy}, 32'h0);
    stall_mask = '0;
    cnt = 0;
    while (y != 32'h0 && cnt < stalls) begin
      n = $urandom_range(2, 60);
      if (!stall_mask[n]) begin
        stall_mask[n] = 1'b1;
        cnt++;
      end
    end
    acc_cyc = cyc + 1;
    start   = 1'b1;
    op      = o;
    a       = x;
    b       = y;
    e.res   = exp;
    e.name  = name;
    e.due   = (y == 32'h0) ? acc_cyc : acc_cyc + 68 + cnt;
    e.nreq  = (y == 32'h0) ? 0 : 68 + cnt;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          guard;
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_alu_req", {31'b0, alu_req}, 32'h0);
    check("reset_alu_op", {28'b0, alu_op}, 32'h0);
    check("reset_alu_a", alu_a, 32'h0);
    check("reset_alu_b", alu_b, 32'h0);
    rst = 1'b0;

    issue("divu_100_7", 2'b01, 32'd100, 32'd7, 0, 32'd14);
    issue("remu_100_7", 2'b11, 32'd100, 32'd7, 0, 32'd2);
    issue("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD);
    issue("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF);
    issue("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD);
    issue("divu_5_0", 2'b01, 32'd5, 32'd0, 0, 32'hFFFF_FFFF);
    issue("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 0, 32'hFFFF_FFFB);
    issue("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    issue("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0);
    issue("divu_stall", 2'b01, 32'hFFFF_FFFF, 32'd3, 10, 32'h5555_5555);

    // A start while busy must be ignored
    issue("divu_busy_start", 2'b01, 32'd1000, 32'd10, 2, 32'd100);
    repeat (10) @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    a     = $urandom;
    b     = $urandom | 32'h1;
    @(negedge clk);
    start = 1'b0;

    // Reset mid-operation abandons it without a done pulse
    issue("pre_reset", 2'b01, $urandom, $urandom | 32'h1, 0, 32'h0);
    repeat (28) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    stall_mask = '0;
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_done", {31'b0, done}, 32'h0);
    check("rst_mid_result", result, 32'h0);
    repeat (80) @(negedge clk);
    issue("divu_9_3", 2'b01, 32'd9, 32'd3, 0, 32'd3);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'h1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom_range(1, 15));
        4:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      issue($sformatf("rand%0d", i), ro, ra, rb, $urandom_range(0, 4), ref_div(ro, ra, rb));
    end

    guard = 0;
    while ((busy || sb.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_scoreboard", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tinyqv_div_sequencer.md
Name: tinyqv_div_sequencer

Overview:
- Multi-cycle sequencer for the RISC-V M-extension DIV, DIVU, REM and REMU operations.
- Does not contain its own adder. It borrows the shared 32-bit ALU (tinyqv_alu) through a request/grant port and runs a restoring-division loop on it using the ALU's SUB and SLTU operations.
- Sits beside the core's execute stage; the core holds the instruction until done.

Parameters:
- none (32-bit datapath fixed)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a division; accepted only when busy=0
- op  in  2  bit0=unsigned, bit1=remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU)
- a  in  32  dividend, sampled on accept
- b  in  32  divisor, sampled on accept
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result valid
- result  out  32  quotient or remainder; held until next accept
- alu_req  out  1  sequencer needs the ALU this cycle
- alu_gnt  in  1  ALU granted to the sequencer this cycle
- alu_op  out  4  ALU opcode (SUB 1000, SLTU 0011)
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_d  in  32  ALU result
- alu_cmp  in  1  ALU compare result (for SLTU: 1 when A<B unsigned)

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, result=0, alu_req=0, alu_op/alu_a/alu_b=0, all internal registers 0. Reset mid-operation abandons the operation; there is no done pulse.
- Registers:
  - Q: 32-bit dividend/quotient shift register.
  - R: 32-bit partial remainder.
  - D: 32-bit divisor.
  - cnt: 5-bit iteration counter.
  - Flags: take, neg_q, neg_r, is_rem.
- IDLE, accepting start (start=1):
  - Latch Q=a, D=b, R=0, cnt=0, is_rem=op[1].
  - Set neg_q = ~op[0] & (a[31]^b[31]) and neg_r = ~op[0] & a[31].
- IDLE, divide by zero (b==0 at accept):
  - Go to DONE immediately; no ALU use.
  - result = (op[1] ? a : 32'hFFFFFFFF).
- start while busy=1 is ignored.
- ALU-using states: ABS_A, ABS_B, CMP, SUB, FIX_Q, FIX_R.
  - In these states alu_req=1.
  - If alu_gnt=0, the state and all registers hold; outputs stay stable.
  - alu_req=0 in IDLE and DONE.
- ABS_A: op SUB, A=0, B=Q. If signed and Q[31], Q<=alu_d.
- ABS_B: op SUB, A=0, B=D. If signed and D[31], D<=alu_d.
- Definitions: Rs = {R[30:0],Q[31]}; hi = R[31].
- CMP: op SLTU, A=Rs, B=D. take <= hi | ~alu_cmp.
- SUB: op SUB, A=Rs, B=D.
  - R <= take ? alu_d : Rs.
  - Q <= {Q[30:0],take}.
  - cnt <= cnt+1.
  - Go to CMP, or to FIX_Q when cnt==31.
  - The modulo-2^32 subtraction is exact when hi=1, since the true remainder is <2^32.
- FIX_Q: op SUB, A=0, B=Q. If neg_q, Q<=alu_d.
- FIX_R: op SUB, A=0, B=R. If neg_r, R<=alu_d.
- After FIX_R, go to DONE with result <= is_rem ? R : Q.
- DONE: done=1 for exactly one cycle, then IDLE.
  - busy=1 from the cycle after accept through DONE inclusive.
  - start is accepted again in the cycle after DONE.
- Latency with alu_gnt held high: 68 ALU cycles (2 abs + 64 loop + 2 fix). done is high in the 69th cycle after the accept edge. Each cycle with alu_gnt=0 adds one cycle.
- Divide-by-zero latency: done is high in the 1st cycle after accept.
- Signed overflow (0x80000000 / -1) falls out of the algorithm: quotient 0x80000000, remainder 0. It needs no special case.
- The ABS and FIX steps always take one granted cycle each, even for unsigned ops, so latency is fixed.

Decomposition:
- Shared package holds the ALU opcode constants (ALU_ADD 4'b0000, ALU_SUB 4'b1000, ALU_SLTU 4'b0011), the op-field bit positions (OP_UNSIGNED=0, OP_REM=1) and the state enumeration (IDLE, ABS_A, ABS_B, CMP, SUB, FIX_Q, FIX_R, DONE).
- Single module; no sub-module. The ALU instance and the grant mux stay external so the ALU remains shared with the core.

Test Plan:
- DIVU a=100, b=7, gnt=1 -> done at cycle 69, result=14; repeat with REMU -> result=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFD (-3); REM -> result=0xFFFFFFFF (-1); DIV a=7, b=-2 -> -3.
- Divide by zero: DIVU a=5, b=0 -> done at cycle 1, result=0xFFFFFFFF; REM a=-5, b=0 -> result=0xFFFFFFFB; alu_req never asserted.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000; REM -> 0.
- Grant stalls: DIVU 0xFFFFFFFF / 3 with alu_gnt low for 10 random cycles -> result=0x55555555, done at cycle 79, ALU outputs stable during stalls.
- Control: start pulsed while busy -> ignored, first result unchanged. rst asserted at cycle 30 -> busy=0, no done, next DIVU 9/3 -> result=3.
